// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: core (m0) and loader/debug (m1).
// Combinational grant, round-robin on ties, bounded lock bursts, registered read return.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int RUN_W = $clog2(MAX_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BURST);

  logic             owner_reg, owner_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic             owner_lock;
  logic             keep;

  // A lock only extends a run that is still live: after an idle cycle (run = 0)
  // the tie goes to the non-owner whatever the owner's lock says.
  always_comb begin
    owner_lock = owner_reg ? m1_lock : m0_lock;
    keep       = owner_lock && (run_reg != '0) && (run_reg < RUN_MAX);
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    if (m0_req && m1_req) begin
      if (keep) begin
        m0_gnt = ~owner_reg;
        m1_gnt = owner_reg;
      end else begin
        m0_gnt = owner_reg;
        m1_gnt = ~owner_reg;
      end
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  assign m0_stall = m0_req & ~m0_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (m0_gnt) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_we;
      mem_re    = ~m0_we;
    end else if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
      mem_re    = ~m1_we;
    end
  end

  // run counts consecutive grants of the owner; nonzero run means it was granted last cycle.
  always_comb begin
    owner_next = owner_reg;
    run_next   = '0;
    if (m0_gnt || m1_gnt) begin
      owner_next = m1_gnt;
      if ((m1_gnt == owner_reg) && (run_reg != '0)) begin
        run_next = (run_reg == RUN_MAX) ? RUN_MAX : run_reg + RUN_W'(1);
      end else begin
        run_next = RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg <= 1'b1;
      run_reg   <= '0;
    end else begin
      owner_reg <= owner_next;
      run_reg   <= run_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_stall, mem_we, mem_re;
  logic [DW-1:0] m0_rdata, m1_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Single-port memory, 64 words indexed by addr[5:0]; filled with a pattern at the first edge.
  logic [DW-1:0] mem [0:63];
  logic          mem_init_done = 1'b0;
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  // Every step: inputs driven at posedge+1, outputs sampled at the negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic r0, r1, l0, l1, w0, w1;
    logic g0, g1;
  } vec_t;

  vec_t vecs[15];

  // Reference model state (transaction level).
  logic [DW-1:0] model_mem [0:63];
  int            m_owner, m_last, m_streak;
  logic          exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  logic          p_req [2], p_we [2], p_lock [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wd [2];

  initial begin
    int g, stalls;
    logic e_we, e_re;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [1:0] exp_seq;

    idle();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'hA500_0000 | 32'(i);

    //          r0 r1 l0 l1 w0 w1  g0 g1
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{1, 1, 1, 0, 1, 0, 1, 0};
    vecs[3]  = '{1, 1, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 1, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 1, 0, 1};
    vecs[6]  = '{0, 1, 0, 1, 0, 0, 0, 1};
    vecs[7]  = '{1, 1, 0, 1, 0, 0, 0, 1};
    vecs[8]  = '{1, 1, 0, 1, 1, 0, 0, 1};
    vecs[9]  = '{1, 1, 0, 1, 0, 0, 1, 0};
    vecs[10] = '{1, 1, 0, 1, 0, 0, 0, 1};
    vecs[11] = '{0, 0, 1, 1, 0, 0, 0, 0};
    vecs[12] = '{1, 1, 0, 1, 0, 0, 1, 0};
    vecs[13] = '{0, 1, 1, 0, 0, 0, 0, 1};
    vecs[14] = '{1, 1, 1, 0, 0, 0, 1, 0};

    // Reset state
    @(negedge clk);
    chk("reset m0_rvalid", 32'(m0_rvalid), 0);
    chk("reset m1_rvalid", 32'(m1_rvalid), 0);
    chk("reset m0_rdata", m0_rdata, 0);
    chk("reset m1_rdata", m1_rdata, 0);
    chk("reset mem_re", 32'(mem_re), 0);
    next_cycle();
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      m0_req = vecs[i].r0; m1_req = vecs[i].r1;
      m0_lock = vecs[i].l0; m1_lock = vecs[i].l1;
      m0_we = vecs[i].w0; m1_we = vecs[i].w1;
      m0_addr = 32'h100; m1_addr = 32'h200;
      m0_wdata = 32'h0000_1111; m1_wdata = 32'h0000_2222;
      @(negedge clk);
      $display("vec %0d: req=%b%b lock=%b%b gnt=%b%b", i, m0_req, m1_req, m0_lock, m1_lock, m0_gnt, m1_gnt);
      chk($sformatf("vec%0d m0_gnt", i), 32'(m0_gnt), 32'(vecs[i].g0));
      chk($sformatf("vec%0d m1_gnt", i), 32'(m1_gnt), 32'(vecs[i].g1));
      chk($sformatf("vec%0d m0_stall", i), 32'(m0_stall), 32'(vecs[i].r0 & ~vecs[i].g0));
      e_we = vecs[i].g0 ? vecs[i].w0 : (vecs[i].g1 ? vecs[i].w1 : 1'b0);
      e_re = vecs[i].g0 ? ~vecs[i].w0 : (vecs[i].g1 ? ~vecs[i].w1 : 1'b0);
      e_addr = vecs[i].g0 ? 32'h100 : (vecs[i].g1 ? 32'h200 : 32'h0);
      chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(e_we));
      chk($sformatf("vec%0d mem_re", i), 32'(mem_re), 32'(e_re));
      chk($sformatf("vec%0d mem_addr", i), mem_addr, e_addr);
      next_cycle();
    end

    // Uncontended read: preload 0x10 through the loader, then m0 reads it
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("preload m1_gnt", 32'(m1_gnt), 1);
    chk("preload mem_we", 32'(mem_we), 1);
    next_cycle();
    idle();
    m0_req = 1; m0_addr = 32'h10;
    @(negedge clk);
    $display("seq uncontended: m0 read 0x10 gnt=%b stall=%b", m0_gnt, m0_stall);
    chk("unc m0_gnt", 32'(m0_gnt), 1);
    chk("unc m0_stall", 32'(m0_stall), 0);
    chk("unc mem_re", 32'(mem_re), 1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("unc m0_rvalid", 32'(m0_rvalid), 1);
    chk("unc m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("unc m1_rvalid", 32'(m1_rvalid), 0);
    chk("unc m1_rdata", m1_rdata, 0);
    next_cycle();
    @(negedge clk);
    chk("unc rvalid pulse", 32'(m0_rvalid), 0);
    chk("unc rdata hold", m0_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Reset mid-read, then tie at reset release and alternating grants
    m0_req = 1; m0_addr = 32'h10;
    @(negedge clk);
    chk("rmr m0_gnt", 32'(m0_gnt), 1);
    #4;
    rst_n = 1'b0;
    m0_req = 0;
    next_cycle();
    @(negedge clk);
    $display("seq reset mid-read: m0_rvalid=%b m0_rdata=%h", m0_rvalid, m0_rdata);
    chk("rmr m0_rvalid", 32'(m0_rvalid), 0);
    chk("rmr m0_rdata", m0_rdata, 0);
    next_cycle();
    rst_n = 1'b1;
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h14;
    exp_seq = 2'b00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      $display("seq tie c%0d: gnt=%b%b", c, m0_gnt, m1_gnt);
      chk($sformatf("tie c%0d m0_gnt", c), 32'(m0_gnt), 32'((c % 2) == 0));
      chk($sformatf("tie c%0d m1_gnt", c), 32'(m1_gnt), 32'((c % 2) == 1));
      chk($sformatf("tie c%0d m0_stall", c), 32'(m0_stall), 32'((c % 2) == 1));
      chk($sformatf("tie c%0d m0_rvalid", c), 32'(m0_rvalid), 32'(exp_seq[0]));
      chk($sformatf("tie c%0d m1_rvalid", c), 32'(m1_rvalid), 32'(exp_seq[1]));
      if (c > 0 && exp_seq[0]) chk($sformatf("tie c%0d m0_rdata", c), m0_rdata, 32'hDEAD_BEEF);
      if (exp_seq[1]) chk($sformatf("tie c%0d m1_rdata", c), m1_rdata, 32'hA500_0014);
      exp_seq = ((c % 2) == 0) ? 2'b01 : 2'b10;
      next_cycle();
    end

    // Lock burst: m1 locks against a continuously requesting m0
    do_reset();
    m0_req = 1; m0_addr = 32'h10;
    @(negedge clk);
    chk("burst c0 m0_gnt", 32'(m0_gnt), 1);
    next_cycle();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h14;
    stalls = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      $display("seq burst c%0d: gnt=%b%b stall=%b", c, m0_gnt, m1_gnt, m0_stall);
      chk($sformatf("burst c%0d m1_gnt", c), 32'(m1_gnt), 32'(c <= 4));
      chk($sformatf("burst c%0d m0_gnt", c), 32'(m0_gnt), 32'(c == 5));
      if (m0_stall) stalls++;
      next_cycle();
    end
    chk("burst stall cycles", 32'(stalls), 4);

    // Write then read by m1 at 0x20
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
    @(negedge clk);
    $display("seq wr/rd: write gnt=%b mem_we=%b", m1_gnt, mem_we);
    chk("wr mem_we", 32'(mem_we), 1);
    chk("wr mem_re", 32'(mem_re), 0);
    chk("wr mem_addr", mem_addr, 32'h20);
    chk("wr mem_wdata", mem_wdata, 32'h1234_5678);
    next_cycle();
    m1_we = 0;
    @(negedge clk);
    chk("wr no rvalid", 32'(m1_rvalid), 0);
    chk("rd mem_re", 32'(mem_re), 1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("rd m1_rvalid", 32'(m1_rvalid), 1);
    chk("rd m1_rdata", m1_rdata, 32'h1234_5678);
    next_cycle();

    // Idle gap: owner m1 locking still loses the tie after idle cycles
    next_cycle();
    m0_req = 1; m1_req = 1; m1_lock = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    @(negedge clk);
    $display("seq idle gap: gnt=%b%b", m0_gnt, m1_gnt);
    chk("gap m0_gnt", 32'(m0_gnt), 1);
    chk("gap m1_gnt", 32'(m1_gnt), 0);
    next_cycle();

    // Randomized run against the reference model
    do_reset();
    m_owner = 1; m_last = -1; m_streak = 0;
    for (int m = 0; m < 2; m++) begin
      exp_rv[m] = 0; exp_rd[m] = '0; p_req[m] = 0; p_we[m] = 0;
      p_lock[m] = 0; p_addr[m] = '0; p_wd[m] = '0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_req[m] && $urandom_range(0, 99) < 55) begin
          p_req[m]  = 1;
          p_we[m]   = 1'($urandom_range(0, 1));
          p_addr[m] = ($urandom & 32'hFFFF_FFC0) | 32'(40 + $urandom_range(0, 23));
          p_wd[m]   = $urandom;
        end
        p_lock[m] = ($urandom_range(0, 3) != 0);
      end
      m0_req = p_req[0]; m0_we = p_we[0]; m0_lock = p_lock[0]; m0_addr = p_addr[0]; m0_wdata = p_wd[0];
      m1_req = p_req[1]; m1_we = p_we[1]; m1_lock = p_lock[1]; m1_addr = p_addr[1]; m1_wdata = p_wd[1];

      g = -1;
      if (p_req[0] && p_req[1]) begin
        if (m_last == m_owner && p_lock[m_owner] && m_streak < MB) g = m_owner;
        else g = 1 - m_owner;
      end else if (p_req[0]) g = 0;
      else if (p_req[1]) g = 1;

      @(negedge clk);
      chk($sformatf("rnd%0d m0_gnt", c), 32'(m0_gnt), 32'(g == 0));
      chk($sformatf("rnd%0d m1_gnt", c), 32'(m1_gnt), 32'(g == 1));
      chk($sformatf("rnd%0d m0_stall", c), 32'(m0_stall), 32'(p_req[0] && g != 0));
      chk($sformatf("rnd%0d mem_we", c), 32'(mem_we), 32'(g >= 0 && p_we[g]));
      chk($sformatf("rnd%0d mem_re", c), 32'(mem_re), 32'(g >= 0 && !p_we[g]));
      chk($sformatf("rnd%0d mem_addr", c), mem_addr, (g >= 0) ? p_addr[g] : 32'h0);
      chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, (g >= 0) ? p_wd[g] : 32'h0);
      chk($sformatf("rnd%0d m0_rvalid", c), 32'(m0_rvalid), 32'(exp_rv[0]));
      chk($sformatf("rnd%0d m1_rvalid", c), 32'(m1_rvalid), 32'(exp_rv[1]));
      chk($sformatf("rnd%0d m0_rdata", c), m0_rdata, exp_rd[0]);
      chk($sformatf("rnd%0d m1_rdata", c), m1_rdata, exp_rd[1]);

      exp_rv[0] = 0; exp_rv[1] = 0;
      if (g >= 0) begin
        if (p_we[g]) model_mem[p_addr[g][5:0]] = p_wd[g];
        else begin
          exp_rv[g] = 1;
          exp_rd[g] = model_mem[p_addr[g][5:0]];
        end
        p_req[g] = 0;
        m_streak = (g == m_last) ? m_streak + 1 : 1;
        m_owner  = g;
        m_last   = g;
      end else begin
        m_last   = -1;
        m_streak = 0;
      end
      next_cycle();
    end
    $display("random run: 2000 cycles done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
